// File: rtl/ped_request_conditioner_if.sv
// Pedestrian request conditioner bundle: raw button and grant in, request/lamp/cooldown out.
// PRESS_COUNT_EN adds the 8-bit accepted-press counter to the bundle.
interface ped_request_conditioner_if;
    logic       button_raw;
    logic       pg;
    logic       button;
    logic       req_led;
    logic       locked;
`ifdef PRESS_COUNT_EN
    logic [7:0] press_cnt;
`endif

    // Controller/stimulus side
    modport master (
        output button_raw,
        output pg,
        input  button,
        input  req_led,
`ifdef PRESS_COUNT_EN
        input  press_cnt,
`endif
        input  locked
    );

    // Conditioner side
    modport slave (
        input  button_raw,
        input  pg,
        output button,
        output req_led,
`ifdef PRESS_COUNT_EN
        output press_cnt,
`endif
        output locked
    );
endinterface

// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner: synchronises and debounces the raw push-button, latches one
// request per press until the controller grants pedestrian green, then enforces a cooldown.
// Optional feature macro: PRESS_COUNT_EN (adds a saturating count of accepted presses).
module ped_request_conditioner #(
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter int unsigned LOCKOUT_CYCLES = 50000000
) (
    input logic                      i_clk,
    input logic                      i_rst,  // synchronous, active-low
    ped_request_conditioner_if.slave io_ped
);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StServing,
        StLockout
    } state_t;

    logic [1:0]        r_sync;
    logic              r_deb;
    logic              r_deb_prev;
    logic [DEB_W-1:0]  r_deb_cnt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_nxt;
    logic              r_button;
    logic              r_req_led;
    logic              r_locked;
    logic              w_press;

    // Two-flop synchroniser; the only path from the raw button into the design
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], io_ped.button_raw};
        end
    end

    // Debounce: level toggles only after DEB_CYCLES consecutive mismatching samples
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_deb_prev <= r_deb;
            if (r_sync[1] == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_deb     <= ~r_deb;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // One-cycle press pulse on the debounced rising edge; releases are ignored
    assign w_press = r_deb & ~r_deb_prev;

    // Next-state and lockout-counter logic; PG always wins over a press
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_cnt;
        case (r_state)
            StIdle: begin
                if (io_ped.pg) begin
                    w_state_nxt = StServing;
                end else if (w_press) begin
                    w_state_nxt = StArmed;
                end
            end
            StArmed: begin
                if (io_ped.pg) begin
                    w_state_nxt = StServing;
                end
            end
            StServing: begin
                if (!io_ped.pg) begin
                    w_state_nxt = StLockout;
                    w_lock_nxt  = LOCK_W'(LOCKOUT_CYCLES - 1);
                end
            end
            StLockout: begin
                if (io_ped.pg) begin
                    w_state_nxt = StServing;
                end else if (r_lock_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_lock_nxt = r_lock_cnt - LOCK_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, counter and outputs registered together so outputs track the state exactly
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_lock_cnt <= '0;
            r_button   <= 1'b0;
            r_req_led  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_button   <= (w_state_nxt == StArmed);
            r_req_led  <= (w_state_nxt == StArmed) || (w_state_nxt == StServing);
            r_locked   <= (w_state_nxt == StLockout);
        end
    end

    assign io_ped.button  = r_button;
    assign io_ped.req_led = r_req_led;
    assign io_ped.locked  = r_locked;

`ifdef PRESS_COUNT_EN
    logic [7:0] r_press_cnt;
    logic       w_accept;

    assign w_accept = (r_state == StIdle) && (w_state_nxt == StArmed);

    // Saturating count of presses accepted from idle; absorbed presses do not count
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_press_cnt <= 8'd0;
        end else if (w_accept && (r_press_cnt != 8'hff)) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    assign io_ped.press_cnt = r_press_cnt;
`endif
endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
- Upstream stage of the crosswalk controller: converts the raw, asynchronous pedestrian push-button into the clean, latched BUTTON request that the controller consumes.
- Synchronises and debounces the raw input, latches a single request per press, and holds it until the controller grants pedestrian green (PG).
- After the walk phase ends, enforces a cooldown during which new presses are ignored.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a new debounced level (10 ms at 50 MHz); must be >= 2.
- LOCKOUT_CYCLES, 50000000, cooldown length in cycles after PG falls (1 s at 50 MHz); must be >= 1.
- Counter widths are $clog2(param+1).

Ports:
- CLK  input  1  system clock, 50 MHz, all logic rising-edge.
- RST  input  1  synchronous, active-low reset (sampled on CLK rising edge; 0 = reset).
- BUTTON_RAW  input  1  raw push-button, asynchronous, bouncing, active-high.
- PG  input  1  pedestrian green from the crosswalk controller; acts as grant/acknowledge.
- BUTTON  output  1  registered request to the crosswalk controller.
- REQ_LED  output  1  "wait" lamp; high while a request is pending or being served.
- LOCKED  output  1  high during the cooldown window.

Behaviour:
- Reset (RST=0 at an edge): all flops cleared. Synchroniser = 0, debounced level = 0, debounce counter = 0, state = IDLE. BUTTON=0, REQ_LED=0, LOCKED=0. A reset mid-operation abandons any pending request.
- Synchroniser: two-flop chain on BUTTON_RAW. It is the only path from the raw input.
- Debounce:
  - When the sync output equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. On reaching DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - A single-cycle mismatch resets progress.
  - Latency from a clean raw edge to a debounced edge is 2 + DEB_CYCLES cycles.
- Press event: a one-cycle pulse on the debounced rising edge only. Releases generate nothing.
- FSM states: IDLE, ARMED, SERVING, LOCKOUT.
  - IDLE: a press moves to ARMED.
  - ARMED: BUTTON=1, REQ_LED=1. PG=1 moves to SERVING. Extra presses are absorbed; only one request is outstanding.
  - SERVING: BUTTON=0, REQ_LED=1. PG=0 moves to LOCKOUT, loads the lockout counter with LOCKOUT_CYCLES-1, and sets LOCKED=1.
  - LOCKOUT: the counter decrements each cycle; presses are ignored. At count 0, move to IDLE and set LOCKED=0. Total lockout duration is exactly LOCKOUT_CYCLES cycles.
- PG=1 while in IDLE or LOCKOUT (controller-initiated walk): move to SERVING without raising BUTTON.
- A press in the same cycle as entry to IDLE from LOCKOUT is accepted, i.e. IDLE evaluates the press normally on its first cycle.
- All outputs are registered and decoded from state. BUTTON rises one cycle after the press pulse.
- PG is treated as synchronous to CLK; no extra synchroniser is used.

Optional Feature:
- Macro PRESS_COUNT_EN.
- Defined:
  - Adds output PRESS_CNT [7:0].
  - Counts presses accepted from IDLE (IDLE->ARMED transitions) only.
  - Saturates at 255 and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (DEB_CYCLES=4, LOCKOUT_CYCLES=10):
- Reset: hold RST=0 for 3 cycles with BUTTON_RAW=1 -> BUTTON=0, REQ_LED=0, LOCKED=0 throughout. After release with raw held at 1: press accepted, BUTTON=1 exactly 2+4+1 cycles later.
- Bounce rejection: toggle BUTTON_RAW every 2 cycles for 40 cycles, then hold 0 -> BUTTON never asserts.
- Clean press: BUTTON_RAW high for 20 cycles -> BUTTON=1 at cycle 7 and held after release. Then PG=1 for 5 cycles -> BUTTON=0 one cycle after PG rise, REQ_LED=1 until PG falls.
- Lockout: PG falls -> LOCKED=1 for exactly 10 cycles. A clean press during this window gives BUTTON=0. A press completing on the cycle LOCKED falls -> BUTTON=1 next cycle.
- Reset mid-ARMED: RST=0 for 1 cycle while BUTTON=1 -> BUTTON=0 next cycle, state IDLE, no spurious re-request.
- PRESS_COUNT_EN: 3 accepted presses plus 2 absorbed in ARMED -> PRESS_CNT=3. Force 300 accepted presses -> PRESS_CNT=255.
